// File: rtl/wb_arbiter.sv
// Two-master to one-slave Wishbone B4 classic arbiter with round-robin grant per
// CYC transaction and a watchdog that turns a hung slave into an ERR to the owner.
`timescale 1ns/1ps
module wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_CYC,
  input  logic        m0_STB,
  input  logic        m0_WE,
  input  logic [31:0] m0_ADR,
  input  logic [31:0] m0_DAT_O,
  input  logic [2:0]  m0_CTI_O,
  output logic        m0_ACK,
  output logic        m0_ERR,
  output logic        m0_RTY,
  output logic [31:0] m0_DAT_I,
  input  logic        m1_CYC,
  input  logic        m1_STB,
  input  logic        m1_WE,
  input  logic [31:0] m1_ADR,
  input  logic [31:0] m1_DAT_O,
  input  logic [2:0]  m1_CTI_O,
  output logic        m1_ACK,
  output logic        m1_ERR,
  output logic        m1_RTY,
  output logic [31:0] m1_DAT_I,
  output logic        s_CYC,
  output logic        s_STB,
  output logic        s_WE,
  output logic [31:0] s_ADR,
  output logic [31:0] s_DAT_O,
  output logic [2:0]  s_CTI_O,
  input  logic        s_ACK,
  input  logic        s_ERR,
  input  logic        s_RTY,
  input  logic [31:0] s_DAT_I,
  output logic [1:0]  grant,
  output logic        timeout
);

  // The counter only has to reach TIMEOUT_CYCLES-1 before the watchdog fires.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic WD_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t           state;
  logic             owner;
  logic             last_owner;
  logic [CNT_W-1:0] wd_cnt;

  logic        o_cyc, o_stb, o_we;
  logic [31:0] o_adr, o_dat;
  logic [2:0]  o_cti;
  logic        busy, resp, fire;

  assign o_cyc = owner ? m1_CYC   : m0_CYC;
  assign o_stb = owner ? m1_STB   : m0_STB;
  assign o_we  = owner ? m1_WE    : m0_WE;
  assign o_adr = owner ? m1_ADR   : m0_ADR;
  assign o_dat = owner ? m1_DAT_O : m0_DAT_O;
  assign o_cti = owner ? m1_CTI_O : m0_CTI_O;

  assign busy = (state == BUSY);
  assign resp = s_ACK | s_ERR | s_RTY;
  // Requiring o_cyc makes an owner release in the firing cycle win over the watchdog.
  assign fire = WD_EN & busy & o_cyc & o_stb & ~resp & (wd_cnt == CNT_LAST);

  assign s_CYC   = busy & o_cyc & ~fire;
  assign s_STB   = busy & o_stb & ~fire;
  assign s_WE    = busy & o_we;
  assign s_ADR   = busy ? o_adr : '0;
  assign s_DAT_O = busy ? o_dat : '0;
  assign s_CTI_O = busy ? o_cti : '0;

  assign m0_ACK = busy & ~owner & s_ACK;
  assign m0_ERR = busy & ~owner & (s_ERR | fire);
  assign m0_RTY = busy & ~owner & s_RTY;
  assign m1_ACK = busy & owner & s_ACK;
  assign m1_ERR = busy & owner & (s_ERR | fire);
  assign m1_RTY = busy & owner & s_RTY;

  assign m0_DAT_I = s_DAT_I;
  assign m1_DAT_I = s_DAT_I;
  assign timeout  = fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      grant      <= 2'b00;
      wd_cnt     <= '0;
    end else begin
      if (busy && s_STB && !resp) wd_cnt <= wd_cnt + 1'b1;
      else                        wd_cnt <= '0;
      case (state)
        IDLE: begin
          if (m0_CYC && m1_CYC) begin
            owner <= ~last_owner;
            grant <= last_owner ? 2'b01 : 2'b10;
            state <= BUSY;
          end else if (m0_CYC) begin
            owner <= 1'b0;
            grant <= 2'b01;
            state <= BUSY;
          end else if (m1_CYC) begin
            owner <= 1'b1;
            grant <= 2'b10;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!o_cyc) begin
            state      <= IDLE;
            last_owner <= owner;
            grant      <= 2'b00;
          end else if (fire) begin
            state <= ABORT;
          end
        end
        ABORT: begin
          if (!o_cyc) begin
            state      <= IDLE;
            last_owner <= owner;
            grant      <= 2'b00;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule
